// File: rtl/avalon_timer_pkg.sv
// Register map and bit layout shared by the Avalon multi-channel timer and its channels.
package avalon_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_SNAP    = 3'd3;
  localparam logic [2:0] REG_COMPARE = 3'd4;
  localparam logic [2:0] REG_IRQVEC  = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef struct packed {
    logic run;
    logic to;
  } status_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with period reload, timeout flag, snapshot and
// optional PWM compare (enabled by TIMER_PWM_EN).
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic             wr_compare,
  input  logic [CNT_W-1:0] wdata,
  output status_t          status,
  output logic [1:0]       control,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic [CNT_W-1:0] compare,
  output logic             irq,
  output logic             pwm
);

  logic [CNT_W-1:0] counter;
  logic cont, ito, run, to, zero_d, force_reload;
  logic start, stop, zero, timeout;

  assign start   = wr_control && wdata[CTRL_START];
  assign stop    = wr_control && wdata[CTRL_STOP];
  assign zero    = (counter == '0);
  assign timeout = zero && !zero_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= RESET_VAL;
      period       <= RESET_VAL;
      snap         <= '0;
      cont         <= 1'b0;
      ito          <= 1'b0;
      run          <= 1'b0;
      to           <= 1'b0;
      zero_d       <= 1'b0;
      force_reload <= 1'b0;
    end else begin
      force_reload <= wr_period;
      zero_d       <= zero;
      if (wr_period) period <= wdata;
      if (wr_control) begin
        cont <= wdata[CTRL_CONT];
        ito  <= wdata[CTRL_ITO];
      end
      if (wr_snap) snap <= counter;
      // A fresh PERIOD takes effect immediately, even on an idle channel.
      if (force_reload)  counter <= period;
      else if (run)      counter <= zero ? period : counter - CNT_W'(1);
      if (start)                                     run <= 1'b1;
      else if (stop || force_reload || (zero && !cont)) run <= 1'b0;
      if (timeout)        to <= 1'b1;
      else if (wr_status) to <= 1'b0;
    end
  end

`ifdef TIMER_PWM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wr_compare) compare <= wdata;
      pwm <= run && (counter < compare);
    end
  end
`else
  logic unused_compare;
  assign unused_compare = wr_compare;
  assign compare        = '0;
  assign pwm            = 1'b0;
`endif

  assign status  = '{run: run, to: to};
  assign control = {cont, ito};
  assign irq     = to && ito;

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel timer: address decode, channel array and registered read mux.
// PWM outputs are built only when TIMER_PWM_EN is defined.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 99999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);

  localparam int               AW        = $clog2(NUM_CH) + 3;
  localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(RESET_PERIOD);

  logic [AW-1:0]    ch_field;
  logic [2:0]       reg_sel;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic [NUM_CH-1:0] irq_vec;
  status_t          status  [NUM_CH];
  logic [1:0]       control [NUM_CH];
  logic [CNT_W-1:0] period  [NUM_CH];
  logic [CNT_W-1:0] snap    [NUM_CH];
  logic [CNT_W-1:0] compare [NUM_CH];
  logic             unused_wdata;

  assign ch_field     = address >> 3;
  assign reg_sel      = address[2:0];
  assign wr_en        = chipselect && !write_n && (ch_field < AW'(NUM_CH));
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_field == AW'(i));

    timer_channel #(.CNT_W(CNT_W), .RESET_VAL(RESET_VAL)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_status  (sel && (reg_sel == REG_STATUS)),
      .wr_control (sel && (reg_sel == REG_CONTROL)),
      .wr_period  (sel && (reg_sel == REG_PERIOD)),
      .wr_snap    (sel && (reg_sel == REG_SNAP)),
      .wr_compare (sel && (reg_sel == REG_COMPARE)),
      .wdata      (writedata[CNT_W-1:0]),
      .status     (status[i]),
      .control    (control[i]),
      .period     (period[i]),
      .snap       (snap[i]),
      .compare    (compare[i]),
      .irq        (irq_vec[i]),
      .pwm        (pwm_out[i])
    );
  end

  assign irq = |irq_vec;

  // Out-of-range channels match no index and fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_field == AW'(i)) begin
        case (reg_sel)
          REG_STATUS: begin
            rd_next[STAT_RUN] = status[i].run;
            rd_next[STAT_TO]  = status[i].to;
          end
          REG_CONTROL: rd_next = 32'(control[i]);
          REG_PERIOD:  rd_next = 32'(period[i]);
          REG_SNAP:    rd_next = 32'(snap[i]);
          REG_COMPARE: rd_next = 32'(compare[i]);
          REG_IRQVEC:  rd_next = 32'(irq_vec);
          default:     rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer with three channels (channel 3 is out of range).
module tb_avalon_multi_timer;
  import avalon_timer_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 32;
  localparam int RP     = 99999;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [4:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] pwm_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] v;
  int hi;
  int pwm_exp;
  int cmp_exp;

  always #5 clk = ~clk;

  avalon_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_PERIOD(RP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  function automatic logic [4:0] ad(input int ch, input int r);
    return 5'((ch << 3) | r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address    = ad(ch, r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address = ad(ch, r);
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
`ifdef TIMER_PWM_EN
    pwm_exp = 6;
    cmp_exp = 3;
`else
    pwm_exp = 0;
    cmp_exp = 0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
    check("rst_pwm", pwm_out, 0);
    rd(0, REG_PERIOD, v);  check("rst_period", v, RP);
    rd(0, REG_STATUS, v);  check("rst_status", v, 0);
    rd(0, REG_CONTROL, v); check("rst_control", v, 0);

    // Continuous timer, period 4: timeout every 5 cycles.
    wr(0, REG_PERIOD, 4);
    wr(0, REG_CONTROL, 32'h7);
    repeat (4) @(negedge clk);
    check("to1_early", irq, 0);
    @(negedge clk);
    check("to1_rise", irq, 1);
    wr(0, REG_STATUS, 0);
    check("to1_clear", irq, 0);
    repeat (3) @(negedge clk);
    check("to2_early", irq, 0);
    @(negedge clk);
    check("to2_rise", irq, 1);
    wr(0, REG_STATUS, 0);
    check("to2_clear", irq, 0);
    repeat (3) @(negedge clk);
    wr(0, REG_STATUS, 0);          // coincides with the third timeout
    check("clr_vs_event_irq", irq, 1);
    rd(0, REG_STATUS, v);  check("clr_vs_event_status", v, 3);
    wr(0, REG_CONTROL, 32'h8);
    wr(0, REG_STATUS, 0);
    check("ch0_stopped_irq", irq, 0);

    // One-shot on ch1, period 3.
    wr(1, REG_PERIOD, 3);
    wr(1, REG_CONTROL, 32'h5);
    repeat (3) @(negedge clk);
    check("oneshot_early", irq, 0);
    @(negedge clk);
    check("oneshot_rise", irq, 1);
    repeat (8) @(negedge clk);
    rd(1, REG_STATUS, v);  check("oneshot_status", v, 1);
    rd(0, REG_IRQVEC, v);  check("irqvec_ch0", v, 2);
    rd(2, REG_IRQVEC, v);  check("irqvec_ch2", v, 2);
    rd(1, REG_CONTROL, v); check("control_readback", v, 1);
    wr(1, REG_SNAP, 0);
    rd(1, REG_SNAP, v);    check("oneshot_reload", v, 3);
    wr(1, REG_STATUS, 0);
    repeat (10) @(negedge clk);
    rd(1, REG_STATUS, v);  check("oneshot_single", v, 0);
    check("oneshot_irq_off", irq, 0);

    // Snapshot on ch2 ten cycles after start.
    wr(2, REG_PERIOD, 1000);
    wr(2, REG_CONTROL, 32'h6);
    repeat (10) @(negedge clk);
    wr(2, REG_SNAP, 32'hdead);
    rd(2, REG_SNAP, v);    check("snap_ch2", v, 990);
    rd(1, REG_SNAP, v);    check("snap_ch1_kept", v, 3);
    rd(1, REG_PERIOD, v);  check("period_ch1_kept", v, 3);
    wr(2, REG_CONTROL, 32'h8);

    // Out-of-range channel and unused offsets.
    wr(3, REG_PERIOD, 77);
    wr(3, REG_CONTROL, 32'h7);
    rd(3, REG_PERIOD, v);  check("bad_ch_period", v, 0);
    rd(3, REG_IRQVEC, v);  check("bad_ch_irqvec", v, 0);
    rd(0, REG_PERIOD, v);  check("ch0_period_kept", v, 4);
    wr(0, 6, 32'hff);
    rd(0, 6, v);           check("reg6_zero", v, 0);
    rd(0, 7, v);           check("reg7_zero", v, 0);

    // PWM on ch0: period 9, compare 3.
    wr(0, REG_PERIOD, 9);
    wr(0, REG_COMPARE, 3);
    wr(0, REG_CONTROL, 32'h6);
    rd(0, REG_COMPARE, v); check("compare_read", v, cmp_exp);
    repeat (12) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_out[0]) hi++;
      @(negedge clk);
    end
    check("pwm_duty", hi, pwm_exp);
    check("pwm_other_ch", pwm_out[2:1], 0);

    // Reset in the middle of running counts.
    wr(1, REG_CONTROL, 32'h7);
    wr(2, REG_CONTROL, 32'h7);
    repeat (6) @(negedge clk);
    check("pre_reset_irq", irq, 1);
    reset_n = 1'b0;
    #1;
    check("in_reset_irq", irq, 0);
    check("in_reset_pwm", pwm_out, 0);
    check("in_reset_readdata", readdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 6; r++) begin
        rd(ch, r, v);
        check($sformatf("post_reset_ch%0d_reg%0d", ch, r), v, (r == 2) ? RP : 0);
      end
    end
    repeat (20) @(negedge clk);
    check("post_reset_irq", irq, 0);
    check("post_reset_pwm", pwm_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
